// File: rtl/exu_cdb_buf_pkg.sv
// Shared core definitions for the execution-unit result buffers that sit in
// front of the CDB arbiter.
package exu_cdb_buf_pkg;

  // Default widths of the destination physical tag and the ROB index.
  localparam int CDB_TAG_W  = 4;
  localparam int CDB_ID_W   = 4;
  localparam int CDB_DATA_W = 32;

  // One buffered result as it will appear on the CDB.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] wdata;
    logic [CDB_ID_W-1:0]   inst_id;
  } cdb_entry_t;

  // Bundle a result payload into a CDB entry.
  function automatic cdb_entry_t make_entry(
    input logic [CDB_TAG_W-1:0]  tag,
    input logic [CDB_DATA_W-1:0] wdata,
    input logic [CDB_ID_W-1:0]   inst_id
  );
    cdb_entry_t e;
    e.tag     = tag;
    e.wdata   = wdata;
    e.inst_id = inst_id;
    return e;
  endfunction

endpackage

// File: rtl/exu_cdb_buf.sv
// Result buffer between one execution unit (ALU/MDU/LSU/JMP) and the CDB
// arbiter. A small FIFO: results enter from the unit, the head is offered to
// the arbiter on req and leaves when the arbiter grants it with rdy.
// TAG_W/ID_W must stay equal to the package widths, since storage is built
// from the shared cdb_entry_t.
module exu_cdb_buf
  import exu_cdb_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = CDB_TAG_W,
  parameter int ID_W  = CDB_ID_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  // execution unit side
  input  logic                       in_valid,
  output logic                       in_rdy,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [31:0]                in_wdata,
  input  logic [ID_W-1:0]            in_inst_id,
  // CDB arbiter side (exu end of exu2cdb_itf)
  output logic                       req,
  input  logic                       rdy,
  output logic [TAG_W-1:0]           tag,
  output logic [31:0]                wdata,
  output logic [ID_W-1:0]            inst_id,
  // occupancy for debug / perf counters
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  logic do_push;
  logic do_pop;

  // Full/empty come from the occupancy counter; in_rdy never looks at rdy,
  // so a full buffer does not accept even when the head is leaving.
  assign in_rdy  = (cnt < CNT_W'(DEPTH));
  assign req     = (cnt != '0);
  assign do_push = in_valid && in_rdy && !flush;
  assign do_pop  = req && rdy && !flush;
  assign count   = cnt;

  // Head payload straight from storage; stale while req is low.
  assign tag     = mem[rd_ptr].tag;
  assign wdata   = mem[rd_ptr].wdata;
  assign inst_id = mem[rd_ptr].inst_id;

  // Payload storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= make_entry(in_tag, in_wdata, in_inst_id);
    end
  end

  // Pointers and occupancy; flush wins over push and pop. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_cdb_buf.sv
// Bench for exu_cdb_buf: directed vector table, reset corner case, then a
// long random run against a queue-based reference.
module tb_exu_cdb_buf;
  import exu_cdb_buf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_rdy;
  logic [3:0]  in_tag = '0;
  logic [31:0] in_wdata = '0;
  logic [3:0]  in_inst_id = '0;
  logic        req;
  logic        rdy = 1'b0;
  logic [3:0]  tag;
  logic [31:0] wdata;
  logic [3:0]  inst_id;
  logic [2:0]  count;

  int nchk = 0;
  int nerr = 0;

  exu_cdb_buf #(.DEPTH(DEPTH), .TAG_W(4), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_rdy(in_rdy),
    .in_tag(in_tag), .in_wdata(in_wdata), .in_inst_id(in_inst_id),
    .req(req), .rdy(rdy), .tag(tag), .wdata(wdata), .inst_id(inst_id),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic        r;
    logic        fl;
    logic [31:0] d;
    logic        e_req;
    logic [2:0]  e_cnt;
    logic        e_inrdy;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic r, input logic fl,
                              input logic [31:0] d, input logic e_req,
                              input logic [2:0] e_cnt, input logic e_inrdy,
                              input logic [31:0] e_wd);
    vec_t x;
    x.v = v; x.r = r; x.fl = fl; x.d = d;
    x.e_req = e_req; x.e_cnt = e_cnt; x.e_inrdy = e_inrdy; x.e_wd = e_wd;
    return x;
  endfunction

  cdb_entry_t model_q[$];

  initial begin
    // Table: inputs held for one edge, expected outputs just after it.
    tbl.push_back(mk(1, 1, 0, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'd1, 1, 1, 1, 32'd1));
    tbl.push_back(mk(1, 0, 0, 32'd2, 1, 2, 1, 32'd1));
    tbl.push_back(mk(1, 0, 0, 32'd3, 1, 3, 1, 32'd1));
    tbl.push_back(mk(1, 0, 0, 32'd4, 1, 4, 0, 32'd1));
    tbl.push_back(mk(1, 1, 0, 32'h99, 1, 3, 1, 32'd2));
    tbl.push_back(mk(0, 1, 0, 32'h0, 1, 2, 1, 32'd3));
    tbl.push_back(mk(0, 1, 0, 32'h0, 1, 1, 1, 32'd4));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h10, 1, 1, 1, 32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h11, 1, 2, 1, 32'h10));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 1, 0, 32'h12 + k, 1, 2, 1, 32'h11 + k));
    tbl.push_back(mk(1, 0, 0, 32'h20, 1, 3, 1, 32'h18));
    tbl.push_back(mk(1, 1, 1, 32'hBAD, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h30, 1, 1, 1, 32'h30));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0, 0, 1, 32'h0));

    // Reset state.
    #2;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid   = tbl[i].v;
      rdy        = tbl[i].r;
      flush      = tbl[i].fl;
      in_wdata   = tbl[i].d;
      in_tag     = (i == 0) ? 4'd3 : tbl[i].d[3:0];
      in_inst_id = (i == 0) ? 4'd5 : tbl[i].d[7:4];
      @(posedge clk); #1;
      chk($sformatf("vec%0d_req", i), 32'(req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].e_inrdy));
      if (tbl[i].e_req)
        chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].e_wd);
      if (i == 0) begin
        chk("vec0_tag", 32'(tag), 32'd3);
        chk("vec0_inst_id", 32'(inst_id), 32'd5);
      end
    end
    in_valid = 1'b0; rdy = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-stream with two entries buffered.
    in_valid = 1'b1; in_wdata = 32'h40; in_tag = 4'h1; in_inst_id = 4'h1;
    @(posedge clk); #1;
    in_wdata = 32'h41;
    @(posedge clk); #1;
    chk("pre_rst_count", 32'(count), 32'd2);
    in_wdata = 32'h42; rdy = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(req), 32'd0);
    chk("async_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("async_rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    chk("held_rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    in_valid = 1'b1; in_wdata = 32'h55; rdy = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_req", 32'(req), 32'd1);
    chk("post_rst_wdata", wdata, 32'h55);
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_drain", 32'(count), 32'd0);
    rdy = 1'b0;

    // Random traffic against a queue reference.
    model_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic do_push, do_pop;
      cdb_entry_t e;
      in_valid   = ($urandom_range(0, 99) < 60);
      rdy        = ($urandom_range(0, 99) < 50);
      flush      = ($urandom_range(0, 63) == 0);
      in_tag     = 4'($urandom);
      in_wdata   = $urandom;
      in_inst_id = 4'($urandom);
      e = make_entry(in_tag, in_wdata, in_inst_id);
      do_push = in_valid && (model_q.size() < DEPTH) && !flush;
      do_pop  = (model_q.size() != 0) && rdy && !flush;
      @(posedge clk); #1;
      if (flush) model_q.delete();
      else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
      end
      chk("rnd_count", 32'(count), 32'(model_q.size()));
      chk("rnd_count_range", 32'(count <= 3'd4), 32'd1);
      chk("rnd_req", 32'(req), 32'(model_q.size() != 0));
      chk("rnd_in_rdy", 32'(in_rdy), 32'(model_q.size() < DEPTH));
      if (model_q.size() != 0) begin
        chk("rnd_head_wdata", wdata, model_q[0].wdata);
        chk("rnd_head_tag", 32'(tag), 32'(model_q[0].tag));
        chk("rnd_head_inst_id", 32'(inst_id), 32'(model_q[0].inst_id));
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/exu_cdb_buf.md
EXU_CDB_BUF -- requirements
Module: exu_cdb_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries, power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default 4, width of the destination physical tag.
REQ-003 SHALL have parameter ID_W, default 4, width of the instruction id (ROB index).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port flush, input, 1, synchronous pipeline flush; discards every buffered entry.
REQ-007 SHALL have port in_valid, input, 1, execution unit presents a result this cycle.
REQ-008 SHALL have port in_rdy, output, 1, buffer accepts a result this cycle.
REQ-009 SHALL have ports in_tag / in_wdata / in_inst_id, inputs, TAG_W / 32 / ID_W, result payload.
REQ-010 SHALL have port req, output, 1, head entry valid toward the CDB arbiter.
REQ-011 SHALL have port rdy, input, 1, arbiter grants the head this cycle.
REQ-012 SHALL have ports tag / wdata / inst_id, outputs, TAG_W / 32 / ID_W, head entry payload.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy, for debug and perf counters.
REQ-014 SHALL group req/rdy/tag/wdata/inst_id so they connect directly to the exu side of exu2cdb_itf.

Function
REQ-015 SHALL be a FIFO with registered storage, read pointer, write pointer and occupancy counter; there is no other state.
REQ-016 SHALL drive in_rdy = (count < DEPTH); it SHALL NOT depend on rdy (no full-cycle pass-through).
REQ-017 SHALL push the payload at the write pointer when in_valid && in_rdy && !flush.
REQ-018 SHALL drive req = (count != 0), with tag/wdata/inst_id taken combinationally from the head entry.
REQ-019 SHALL pop the head when req && rdy && !flush.
REQ-020 SHALL have a push-to-req latency of exactly one cycle: a result pushed at edge N is visible on req after edge N; there is no same-cycle bypass.
REQ-021 SHALL, on a simultaneous push and pop, advance both pointers and leave count unchanged.
REQ-022 SHALL wrap the pointers modulo DEPTH.
REQ-023 SHALL keep count within 0..DEPTH; full and empty are derived from count, not from pointer equality.
REQ-024 SHALL, when flush is asserted, have priority over push and pop: at the next edge count, rd_ptr and wr_ptr become 0 and the input and head are dropped.
REQ-025 SHALL hold the head payload stable while req=1 and rdy=0.
REQ-026 SHALL allow tag/wdata/inst_id to hold stale values when req=0; consumers SHALL qualify them with req.
REQ-027 SHALL never emit X on req or count after reset.

Reset
REQ-028 SHALL, on rst assertion, immediately clear count, rd_ptr and wr_ptr to 0, so req=0 and in_rdy=1.
REQ-029 SHALL leave payload storage unreset; tag/wdata/inst_id are don't-care while req=0.
REQ-030 SHALL drop an in-flight push or pop coincident with rst; the first accepted push is on the first edge after rst deasserts.

Structure
REQ-031 SHALL take TAG_W and ID_W defaults from the shared core package, together with a packed cdb_entry_t {tag, wdata, inst_id}; the storage array is of cdb_entry_t.
REQ-032 SHALL be one module with no sub-module; one instance is placed between each of ALU, MDU, LSU and JMP and the CDB arbiter.

Verification
REQ-033 Single push of tag=3, wdata=0xDEADBEEF, inst_id=5 with rdy=1 -> req=1 the next cycle with that payload; req=0 and count=0 one cycle later.
REQ-034 rdy=0 and 4 pushes (wdata 1,2,3,4) -> in_rdy=0 and count=4; then rdy=1 -> wdata 1,2,3,4 emitted in order on 4 consecutive cycles.
REQ-035 count=2 with push and pop in the same cycle -> count stays 2, FIFO order preserved, across 8 cycles covering pointer wrap.
REQ-036 count=3 with flush=1 and in_valid=1 -> count=0 and req=0 next cycle; the flushed input never appears.
REQ-037 rst asserted mid-stream with count=2, asynchronously between edges -> req=0, in_rdy=1 and count=0 immediately; after deassert, a push of wdata=0x55 is emitted first.
REQ-038 Random in_valid/rdy over 10k cycles against a scoreboard queue -> no loss, duplication or reorder, and count always within 0..4.
